// File: rtl/frame_buffer.sv
// Double-buffered ROWSxCOLS frame store; writes land in the back bank, swap is deferred to frame_done.
// Write latency 1 cycle; wr_ready drops outside READY (clear/swap/copy take ROWS cycles each).
module frame_buffer #(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [XW-1:0]              wr_x,
  input  logic [YW-1:0]              wr_y,
  input  logic                       wr_data,
  input  logic                       clr_req,
  input  logic                       swap_req,
  input  logic                       frame_done,
  output logic                       busy,
  output logic                       swap_done,
  output logic [ROWS-1:0][COLS-1:0]  matrix
);

  typedef enum logic [1:0] {READY, CLEAR, SWAP_WAIT, COPY} state_t;

  state_t                   state, state_nxt;
  logic [ROWS-1:0][COLS-1:0] bank0, bank1;
  logic                     sel;
  logic [YW-1:0]            r;
  logic                     last_row;
  logic                     wr_fire;
  logic                     x_ok, y_ok;

  // Coordinates that cannot exceed the array need no range check.
  if (COLS == (1 << XW)) begin : g_xfull
    assign x_ok = 1'b1;
  end else begin : g_xpart
    assign x_ok = ({1'b0, wr_x} < (XW+1)'(COLS));
  end

  if (ROWS == (1 << YW)) begin : g_yfull
    assign y_ok = 1'b1;
  end else begin : g_ypart
    assign y_ok = ({1'b0, wr_y} < (YW+1)'(ROWS));
  end

  assign last_row = (r == YW'(ROWS-1));
  assign wr_fire  = wr_valid && wr_ready;
  assign busy     = (state != READY);
  assign matrix   = sel ? bank1 : bank0;

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    case (state)
      READY: begin
        wr_ready = !clr_req && !swap_req;
        if (clr_req)       state_nxt = CLEAR;
        else if (swap_req) state_nxt = SWAP_WAIT;
      end
      CLEAR:     if (last_row)   state_nxt = READY;
      SWAP_WAIT: if (frame_done) state_nxt = COPY;
      COPY:      if (last_row)   state_nxt = READY;
      default:   state_nxt = READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= READY;
      sel       <= 1'b0;
      r         <= '0;
      swap_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      swap_done <= 1'b0;
      case (state)
        READY: r <= '0;
        SWAP_WAIT: begin
          if (frame_done) begin
            sel       <= ~sel;
            r         <= '0;
            swap_done <= 1'b1;
          end
        end
        CLEAR, COPY: r <= last_row ? '0 : r + YW'(1);
        default: r <= '0;
      endcase
    end
  end

  // Back bank is !sel; during COPY sel has already flipped, so the source is the new front.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      case (state)
        READY: begin
          if (wr_fire && x_ok && y_ok) begin
            if (sel) bank0[wr_y][wr_x] <= wr_data;
            else     bank1[wr_y][wr_x] <= wr_data;
          end
        end
        CLEAR: begin
          if (sel) bank0[r] <= '0;
          else     bank1[r] <= '0;
        end
        COPY: begin
          if (sel) bank0[r] <= bank1[r];
          else     bank1[r] <= bank0[r];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: reset, deferred swap, incremental copy, clear, contention, reset mid-copy.
module tb_frame_buffer;

  localparam int COLS = 32;
  localparam int ROWS = 32;

  logic                      clk;
  logic                      reset;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [4:0]                wr_x;
  logic [4:0]                wr_y;
  logic                      wr_data;
  logic                      clr_req;
  logic                      swap_req;
  logic                      frame_done;
  logic                      busy;
  logic                      swap_done;
  logic [ROWS-1:0][COLS-1:0] matrix;

  int errors = 0;
  int checks = 0;
  int cycles;
  int pulses;

  frame_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .swap_req   (swap_req),
    .frame_done (frame_done),
    .busy       (busy),
    .swap_done  (swap_done),
    .matrix     (matrix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_px(input int x, input int y, input logic d);
    wr_valid = 1'b1;
    wr_x     = 5'(x);
    wr_y     = 5'(y);
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  // Counts busy cycles and swap_done pulses until idle; bounded so a stuck FSM still reaches the summary.
  task automatic wait_idle(output int n, output int p);
    n = 0;
    p = 0;
    while (busy && n < 200) begin
      if (swap_done) p++;
      n++;
      tick();
    end
  endtask

  initial begin
    reset      = 1'b0;
    wr_valid   = 1'b0;
    wr_x       = '0;
    wr_y       = '0;
    wr_data    = 1'b0;
    clr_req    = 1'b0;
    swap_req   = 1'b0;
    frame_done = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    check("rst_matrix",    32'(|matrix), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_wr_ready",  32'(wr_ready), 32'd1);
    check("rst_swap_done", 32'(swap_done), 32'd0);

    // Write without swap, then deferred swap
    write_px(3, 5, 1'b1);
    write_px(0, 31, 1'b1);
    check("no_show_before_swap", matrix[5], 32'h0);
    pulse_swap();
    check("swapwait_busy",     32'(busy), 32'd1);
    check("swapwait_wr_ready", 32'(wr_ready), 32'd0);
    repeat (20) tick();
    check("pre_frame_row5", matrix[5], 32'h0);
    pulse_frame();
    check("swap_row5",  matrix[5], 32'h0000_0008);
    check("swap_row31", matrix[31], 32'h0000_0001);
    wait_idle(cycles, pulses);
    check("copy_cycles",      32'(cycles), 32'd32);
    check("swap_done_pulses", 32'(pulses), 32'd1);
    check("copy_ready",       32'(wr_ready), 32'd1);

    // Incremental draw
    write_px(4, 5, 1'b1);
    check("incr_not_shown", matrix[5], 32'h0000_0008);
    pulse_swap();
    tick();
    pulse_frame();
    wait_idle(cycles, pulses);
    check("incr_row5",  matrix[5], 32'h0000_0018);
    check("incr_row31", matrix[31], 32'h0000_0001);
    check("incr_sel",   32'(dut.sel), 32'd0);

    // Clear then swap
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clear_front_kept", matrix[5], 32'h0000_0018);
    wait_idle(cycles, pulses);
    check("clear_cycles",   32'(cycles), 32'd32);
    check("clear_wr_ready", 32'(wr_ready), 32'd1);
    pulse_swap();
    pulse_frame();
    wait_idle(cycles, pulses);
    check("clear_swap_matrix", 32'(|matrix), 32'd0);
    check("clear_swap_sel",    32'(dut.sel), 32'd1);

    // Contention: clear beats swap beats write
    clr_req  = 1'b1;
    swap_req = 1'b1;
    wr_valid = 1'b1;
    wr_x     = 5'd1;
    wr_y     = 5'd1;
    wr_data  = 1'b1;
    #1;
    check("contend_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    clr_req  = 1'b0;
    swap_req = 1'b0;
    wr_valid = 1'b0;
    repeat (3) tick();
    pulse_frame();
    wait_idle(cycles, pulses);
    check("contend_clear_left", 32'(cycles), 32'd28);
    check("contend_no_swap",    32'(pulses), 32'd0);
    check("contend_sel",        32'(dut.sel), 32'd1);

    // frame_done with the accepting swap_req does not count
    write_px(7, 2, 1'b1);
    swap_req   = 1'b1;
    frame_done = 1'b1;
    tick();
    swap_req   = 1'b0;
    frame_done = 1'b0;
    repeat (5) tick();
    check("same_cycle_busy", 32'(busy), 32'd1);
    check("same_cycle_sel",  32'(dut.sel), 32'd1);
    check("same_cycle_row2", matrix[2], 32'h0);
    pulse_frame();
    check("late_swap_done", 32'(swap_done), 32'd1);
    check("late_swap_row2", matrix[2], 32'h0000_0080);
    check("late_swap_row1", matrix[1], 32'h0);
    wait_idle(cycles, pulses);
    check("late_swap_sel", 32'(dut.sel), 32'd0);

    // Reset mid-COPY
    write_px(9, 0, 1'b1);
    pulse_swap();
    pulse_frame();
    check("pre_rst_row0", matrix[0], 32'h0000_0200);
    repeat (9) tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_matrix",    32'(|matrix), 32'd0);
    check("midrst_busy",      32'(busy), 32'd0);
    check("midrst_sel",       32'(dut.sel), 32'd0);
    check("midrst_swap_done", 32'(swap_done), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("postrst_wr_ready", 32'(wr_ready), 32'd1);
    check("postrst_busy",     32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
